out_mapper_gen2: RTL
====================

// Module: out_mapper_gen2
// PURPOSE
//  Parametrised successor SpiNNaker->AER output mapper. Accepts 72-bit SpiNNaker packets from the link receiver,
//  filters multicast (MC) packets, checks parity, decodes N_CMD masked command keys, and queues event keys
//  in a circular FIFO of parametrised depth towards the AER output interface. Adds drop statistics and a level output.
// PARAMETERS
//  AER_WIDTH  32  output event width, 1..32; oaer_data = key[AER_WIDTH-1:0]
//  FIFO_DEPTH 8   event FIFO entries, power of 2, >=2
//  N_CMD      2   number of command key/mask slots, 1..8
//  CNT_WIDTH  16  width of saturating drop counters
// PORTS
//  clk           in   1                    clock
//  rst           in   1                    reset
//  opkt_data     in   72                   packet; [0]=parity, [7:6]=type (00=MC), [39:8]=key
//  opkt_vld      in   1                    packet valid
//  opkt_rdy      out  1                    packet ready (= ~fifo_full)
//  oaer_data     out  AER_WIDTH            head-of-FIFO event
//  oaer_vld      out  1                    FIFO not empty
//  oaer_rdy      in   1                    AER consumer ready
//  cmd_key       in   32*N_CMD             slot i key at [32i+31:32i]
//  cmd_mask      in   32*N_CMD             slot i mask; mask 0 disables slot
//  cmd_pulse     out  N_CMD                one-cycle command strobe per slot
//  parity_err    out  1                    one-cycle pulse on parity-failed MC packet
//  drop_cnt_par  out  CNT_WIDTH            MC packets dropped for bad parity
//  drop_cnt_type out  CNT_WIDTH            non-MC packets dropped
//  clr_cnt       in   1                    synchronous clear of both drop counters
//  fifo_level    out  $clog2(FIFO_DEPTH+1) current occupancy
// BEHAVIOUR
//  - Reset: rst, asynchronous, active-high; clock clk (all flops posedge). Reset values: FIFO empty (ptrs/level 0),
//    oaer_vld=0, opkt_rdy=1, cmd_pulse=0, parity_err=0, both counters 0. Reset mid-operation flushes FIFO contents.
//  - Accept = opkt_vld & opkt_rdy. Every accepted packet is consumed; classification in the same cycle:
//    type!=00 -> drop, drop_cnt_type++; MC & ^opkt_data==0 -> drop, drop_cnt_par++, parity_err=1 next cycle;
//    MC & parity ok & command hit -> cmd_pulse[i]=1 next cycle, not enqueued; otherwise -> write key to FIFO.
//  - Command hit slot i: cmd_mask_i!=0 && (key & cmd_mask_i)==(cmd_key_i & cmd_mask_i); lowest i wins, one-hot pulse.
//  - opkt_rdy=0 while full, so commands also stall when FIFO full (ordering preserved).
//  - FIFO: circular, wr_ptr/rd_ptr wrap modulo FIFO_DEPTH. Write-to-oaer_vld latency 1 cycle (no bypass).
//    oaer_data = mem[rd_ptr] combinationally; read = oaer_vld & oaer_rdy advances rd_ptr.
//  - Simultaneous read & write: level unchanged, both pointers advance; legal at any non-full level incl. 1.
//  - Full: fifo_level==FIFO_DEPTH; read while full frees a slot; opkt_rdy rises the following cycle.
//  - oaer_data stable while oaer_vld & ~oaer_rdy.
//  - Counters saturate at all-ones; clr_cnt has priority over a same-cycle increment.
// CONFIGURATION
//  Macro OUT_MAPPER_PAYLOAD_EN.
//  - Defined: extra ports oaer_pl (out 32) and oaer_pl_vld (out 1). FIFO entry widened by 33 bits storing
//    opkt_data[71:40] and payload flag opkt_data[1]; both ports follow the head entry like oaer_data.
//    Command packets with payload still produce only cmd_pulse.
//  - Not defined: ports absent, opkt_data[71:40] and [1] ignored, FIFO width AER_WIDTH.
// TESTING
//  1. MC key 0x0000_1234, good parity, oaer_rdy=1 -> oaer_vld next cycle, oaer_data=0x1234, level 1->0.
//  2. oaer_rdy=0, 9 good MC pkts (DEPTH=8) -> opkt_rdy=0 after 8th, level=8; drain -> keys in order 1..8, then 9th.
//  3. Bad-parity MC pkt then type=10 pkt -> parity_err pulse once, drop_cnt_par=1, drop_cnt_type=1, FIFO empty.
//  4. slot0 key 0xFFFF_0000 mask 0xFFFF_0000, slot1 key 0xFFFF_0001 mask all-ones; pkt key 0xFFFF_0001 ->
//     cmd_pulse=2'b01 for one cycle, nothing enqueued.
//  5. Level 1, same-cycle read+write for 20 cycles -> level stays 1, data in order across pointer wrap.
//  6. Assert rst with level 5 -> oaer_vld=0 asynchronously, level 0; post-reset first key emerges correctly.

Source files
------------

// File: rtl/out_mapper_gen2.sv
// out_mapper_gen2: SpiNNaker -> AER output mapper.
// Takes 72-bit link packets, keeps multicast packets with good (odd) parity,
// turns command-key hits into one-cycle strobes and queues the remaining event
// keys in a circular FIFO towards the AER side. Bad or non-MC packets are
// counted in saturating drop counters.
// Optional macro OUT_MAPPER_PAYLOAD_EN: carries opkt_data[71:40] and the
// payload flag opkt_data[1] alongside each queued key (oaer_pl/oaer_pl_vld).
module out_mapper_gen2 #(
  parameter int AER_WIDTH  = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int N_CMD      = 2,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [71:0]                       opkt_data,
  input  logic                              opkt_vld,
  output logic                              opkt_rdy,
  output logic [AER_WIDTH-1:0]              oaer_data,
  output logic                              oaer_vld,
  input  logic                              oaer_rdy,
  input  logic [32*N_CMD-1:0]               cmd_key,
  input  logic [32*N_CMD-1:0]               cmd_mask,
  output logic [N_CMD-1:0]                  cmd_pulse,
  output logic                              parity_err,
  output logic [CNT_WIDTH-1:0]              drop_cnt_par,
  output logic [CNT_WIDTH-1:0]              drop_cnt_type,
  input  logic                              clr_cnt,
`ifdef OUT_MAPPER_PAYLOAD_EN
  output logic [31:0]                       oaer_pl,
  output logic                              oaer_pl_vld,
`endif
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(FIFO_DEPTH+1);
`ifdef OUT_MAPPER_PAYLOAD_EN
  localparam int EW = AER_WIDTH + 33;
`else
  localparam int EW = AER_WIDTH;
`endif

  logic [EW-1:0]        mem_q [FIFO_DEPTH];
  logic [EW-1:0]        entry_d, head;
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]        level_q, level_d;
  logic [N_CMD-1:0]     cmd_pulse_q, cmd_pulse_d, hit;
  logic                 parity_err_q, parity_err_d;
  logic [CNT_WIDTH-1:0] cnt_par_q, cnt_par_d, cnt_type_q, cnt_type_d;
  logic [31:0]          key;
  logic                 is_mc, par_ok, found, accept;
  logic                 drop_type, drop_par, cmd_hit, wr_en, rd_en;

  // Packet classification and lowest-index command slot match.
  always_comb begin
    key    = opkt_data[39:8];
    is_mc  = (opkt_data[7:6] == 2'b00);
    par_ok = ^opkt_data;
    accept = opkt_vld & opkt_rdy;
    hit    = '0;
    found  = 1'b0;
    for (int i = 0; i < N_CMD; i++) begin
      if (!found && (cmd_mask[32*i +: 32] != 32'd0) &&
          (((key ^ cmd_key[32*i +: 32]) & cmd_mask[32*i +: 32]) == 32'd0)) begin
        hit[i] = 1'b1;
        found  = 1'b1;
      end
    end
    drop_type = accept & ~is_mc;
    drop_par  = accept & is_mc & ~par_ok;
    cmd_hit   = accept & is_mc & par_ok & found;
    wr_en     = accept & is_mc & par_ok & ~found;
    rd_en     = oaer_vld & oaer_rdy;
`ifdef OUT_MAPPER_PAYLOAD_EN
    entry_d   = {opkt_data[1], opkt_data[71:40], key[AER_WIDTH-1:0]};
`else
    entry_d   = key[AER_WIDTH-1:0];
`endif
  end

  // Next-state for FIFO pointers/level, strobes and saturating counters.
  always_comb begin
    wr_ptr_d = wr_en ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = rd_en ? rd_ptr_q + PW'(1) : rd_ptr_q;
    level_d  = level_q;
    case ({wr_en, rd_en})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    cmd_pulse_d  = cmd_hit ? hit : '0;
    parity_err_d = drop_par;
    cnt_par_d    = cnt_par_q;
    cnt_type_d   = cnt_type_q;
    if (clr_cnt) begin
      cnt_par_d  = '0;
      cnt_type_d = '0;
    end else begin
      if (drop_par  && cnt_par_q  != '1) cnt_par_d  = cnt_par_q  + CNT_WIDTH'(1);
      if (drop_type && cnt_type_q != '1) cnt_type_d = cnt_type_q + CNT_WIDTH'(1);
    end
  end

  // Control state; async reset also flushes the FIFO by zeroing pointers/level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      cmd_pulse_q  <= '0;
      parity_err_q <= 1'b0;
      cnt_par_q    <= '0;
      cnt_type_q   <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      cmd_pulse_q  <= cmd_pulse_d;
      parity_err_q <= parity_err_d;
      cnt_par_q    <= cnt_par_d;
      cnt_type_q   <= cnt_type_d;
    end
  end

  // FIFO storage; contents need no reset since level gates visibility.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= entry_d;
  end

  assign head          = mem_q[rd_ptr_q];
  assign oaer_data     = head[AER_WIDTH-1:0];
  assign oaer_vld      = (level_q != '0);
  assign opkt_rdy      = (level_q != LW'(FIFO_DEPTH));
  assign fifo_level    = level_q;
  assign cmd_pulse     = cmd_pulse_q;
  assign parity_err    = parity_err_q;
  assign drop_cnt_par  = cnt_par_q;
  assign drop_cnt_type = cnt_type_q;
`ifdef OUT_MAPPER_PAYLOAD_EN
  assign oaer_pl       = head[AER_WIDTH +: 32];
  assign oaer_pl_vld   = head[EW-1];
`endif

endmodule
